// File: rtl/control_fsm_pkg.sv
// risc_pkg: shared types and constants for the instruction controller.
//   state_t        controller states
//   instr_class_t  decoded instruction kind
//   OPC_*/OP_*     opcode and op sub-field encodings
//   ALU_*          ALU operation codes driven on ALUop
//   *_MSB/*_LSB    instruction field bit positions
package risc_pkg;

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_WRITE_IMM = 3'd2,
        S_GET_A     = 3'd3,
        S_GET_B     = 3'd4,
        S_ALU       = 3'd5,
        S_WRITE_REG = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CLS_MOV_IMM = 3'd0,
        CLS_MOV_REG = 3'd1,
        CLS_ALU     = 3'd2,
        CLS_CMP     = 3'd3,
        CLS_MVN     = 3'd4,
        CLS_ILLEGAL = 3'd5
    } instr_class_t;

    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_AND    = 2'b10;
    localparam logic [1:0] ALU_NOT    = 2'b11;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 13;
    localparam int OP_MSB  = 12;
    localparam int OP_LSB  = 11;
    localparam int RN_MSB  = 10;
    localparam int RN_LSB  = 8;
    localparam int RD_MSB  = 7;
    localparam int RD_LSB  = 5;
    localparam int SH_MSB  = 4;
    localparam int SH_LSB  = 3;
    localparam int RM_MSB  = 2;
    localparam int RM_LSB  = 0;

endpackage

// File: rtl/control_fsm_if.sv
// control_fsm_if: bundle between the instruction controller and its datapath.
//   master: drives s/instr, observes controls (testbench or sequencer side)
//   slave : the controller; samples s/instr, drives all datapath controls
interface control_fsm_if #(
    parameter int WIDTH = 16
);
    logic             s;
    logic [15:0]      instr;
    logic [2:0]       readnum;
    logic [2:0]       writenum;
    logic             loada;
    logic             loadb;
    logic             loadc;
    logic             loads;
    logic             write;
    logic             vsel;
    logic             asel;
    logic             bsel;
    logic [1:0]       shift;
    logic [1:0]       ALUop;
    logic [WIDTH-1:0] datapath_in;
    logic             w;
    logic             done;
    logic             err;

    modport master (
        output s, instr,
        input  readnum, writenum, loada, loadb, loadc, loads, write, vsel,
               asel, bsel, shift, ALUop, datapath_in, w, done, err
    );

    modport slave (
        input  s, instr,
        output readnum, writenum, loada, loadb, loadc, loads, write, vsel,
               asel, bsel, shift, ALUop, datapath_in, w, done, err
    );
endinterface

// File: rtl/control_fsm_decode.sv
// instr_decode: purely combinational field extraction and classification
// of the latched instruction register.
//   ir_i       instruction register
//   op_o, rn_o, rd_o, sh_o, rm_o  raw fields
//   imm_sext_o imm sign-extended to WIDTH
//   cls_o      instruction kind (MOV imm/reg, ALU, CMP, MVN, illegal)
module instr_decode
    import risc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IMMW  = 8
) (
    input  logic [15:0]      ir_i,
    output logic [1:0]       op_o,
    output logic [2:0]       rn_o,
    output logic [2:0]       rd_o,
    output logic [1:0]       sh_o,
    output logic [2:0]       rm_o,
    output logic [WIDTH-1:0] imm_sext_o,
    output instr_class_t     cls_o
);
    logic [2:0] opcode;

    assign opcode     = ir_i[OPC_MSB:OPC_LSB];
    assign op_o       = ir_i[OP_MSB:OP_LSB];
    assign rn_o       = ir_i[RN_MSB:RN_LSB];
    assign rd_o       = ir_i[RD_MSB:RD_LSB];
    assign sh_o       = ir_i[SH_MSB:SH_LSB];
    assign rm_o       = ir_i[RM_MSB:RM_LSB];
    assign imm_sext_o = {{(WIDTH-IMMW){ir_i[IMMW-1]}}, ir_i[IMMW-1:0]};

    always_comb begin
        cls_o = CLS_ILLEGAL;
        case (opcode)
            OPC_MOV: begin
                if (op_o == OP_MOV_IMM)      cls_o = CLS_MOV_IMM;
                else if (op_o == OP_MOV_REG) cls_o = CLS_MOV_REG;
            end
            OPC_ALU: begin
                case (op_o)
                    OP_MVN:  cls_o = CLS_MVN;
                    OP_CMP:  cls_o = CLS_CMP;
                    default: cls_o = CLS_ALU;
                endcase
            end
            default: cls_o = CLS_ILLEGAL;
        endcase
    end
endmodule

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle instruction sequencer for a simple register datapath.
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      control_fsm_if.slave (s/instr in; datapath strobes, w/done/err out)
//
// state       | meaning
// WAIT        | idle, w=1, accepts s and latches instr
// DECODE      | classify IR; illegal opcode pulses err and returns to WAIT
// WRITE_IMM   | write sign-extended immediate to Rn
// GET_A       | read Rn into A
// GET_B       | read Rm into B
// ALU         | shift/ALU op; CMP loads status and finishes here
// WRITE_REG   | write C to Rd
module control_fsm
    import risc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IMMW  = 8
) (
    input logic          clk,
    input logic          reset_n,
    control_fsm_if.slave bus
);
    state_t       state_q, state_d;
    logic [15:0]  ir_q, ir_d;

    logic [1:0]       op, sh;
    logic [2:0]       rn, rd, rm;
    logic [WIDTH-1:0] imm_sext;
    instr_class_t     cls;

    instr_decode #(.WIDTH(WIDTH), .IMMW(IMMW)) u_decode (
        .ir_i       (ir_q),
        .op_o       (op),
        .rn_o       (rn),
        .rd_o       (rd),
        .sh_o       (sh),
        .rm_o       (rm),
        .imm_sext_o (imm_sext),
        .cls_o      (cls)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_WAIT;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // All outputs decode from state_q/ir_q only, so reset clears them at once.
    always_comb begin
        state_d          = state_q;
        ir_d             = ir_q;
        bus.readnum      = '0;
        bus.writenum     = '0;
        bus.loada        = 1'b0;
        bus.loadb        = 1'b0;
        bus.loadc        = 1'b0;
        bus.loads        = 1'b0;
        bus.write        = 1'b0;
        bus.vsel         = 1'b0;
        bus.asel         = 1'b0;
        bus.bsel         = 1'b0;
        bus.shift        = '0;
        bus.ALUop        = '0;
        bus.datapath_in  = '0;
        bus.w            = 1'b0;
        bus.done         = 1'b0;
        bus.err          = 1'b0;

        case (state_q)
            S_WAIT: begin
                bus.w = 1'b1;
                if (bus.s) begin
                    ir_d    = bus.instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (cls)
                    CLS_MOV_IMM: state_d = S_WRITE_IMM;
                    CLS_MOV_REG,
                    CLS_MVN:     state_d = S_GET_B;
                    CLS_ALU,
                    CLS_CMP:     state_d = S_GET_A;
                    default: begin
                        bus.err = 1'b1;
                        state_d = S_WAIT;
                    end
                endcase
            end
            S_WRITE_IMM: begin
                bus.write       = 1'b1;
                bus.vsel        = 1'b1;
                bus.writenum    = rn;
                bus.datapath_in = imm_sext;
                bus.done        = 1'b1;
                state_d         = S_WAIT;
            end
            S_GET_A: begin
                bus.readnum = rn;
                bus.loada   = 1'b1;
                state_d     = S_GET_B;
            end
            S_GET_B: begin
                bus.readnum = rm;
                bus.loadb   = 1'b1;
                state_d     = S_ALU;
            end
            S_ALU: begin
                bus.shift = sh;
                // MOV reg and MVN ignore A by forcing it to zero.
                case (cls)
                    CLS_MOV_REG: begin bus.asel = 1'b1; bus.ALUop = ALU_ADD; end
                    CLS_MVN:     begin bus.asel = 1'b1; bus.ALUop = ALU_NOT; end
                    default:     bus.ALUop = op;
                endcase
                if (cls == CLS_CMP) begin
                    bus.loads = 1'b1;
                    bus.done  = 1'b1;
                    state_d   = S_WAIT;
                end else begin
                    bus.loadc = 1'b1;
                    state_d   = S_WRITE_REG;
                end
            end
            S_WRITE_REG: begin
                bus.write    = 1'b1;
                bus.writenum = rd;
                bus.done     = 1'b1;
                state_d      = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end
endmodule

// File: tb/tb_control_fsm.sv
module tb_control_fsm;
    typedef struct packed {
        logic w, done, err, loada, loadb, loadc, loads, write, vsel, asel, bsel;
        logic [1:0]  shift;
        logic [1:0]  aluop;
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic [15:0] dp;
    } ctl_t;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_err = 0;
    ctl_t e;

    control_fsm_if #(.WIDTH(16)) bus ();

    control_fsm #(.WIDTH(16), .IMMW(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input ctl_t exp_v);
        ctl_t o;
        o = {bus.w, bus.done, bus.err, bus.loada, bus.loadb, bus.loadc, bus.loads,
             bus.write, bus.vsel, bus.asel, bus.bsel, bus.shift, bus.ALUop,
             bus.readnum, bus.writenum, bus.datapath_in};
        n_checks++;
        assert (o === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, o, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start(input logic [15:0] word);
        bus.s     = 1'b1;
        bus.instr = word;
        tick();
        bus.s     = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        bus.s     = 1'b0;
        bus.instr = 16'h0000;
        #1;
        e = '0; e.w = 1'b1;                    chk("reset_state", e);
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        tick();
        e = '0; e.w = 1'b1;                    chk("idle_no_start", e);

        // MOV R1,#-10
        start(16'hD1F6);
        e = '0;                                chk("movimm_decode", e);
        tick();
        e = '0; e.write = 1; e.vsel = 1; e.writenum = 3'd1; e.dp = 16'hFFF6; e.done = 1;
                                               chk("movimm_write", e);
        tick();
        e = '0; e.w = 1'b1;                    chk("movimm_w_lat2", e);

        // MOV R7,#5 (positive immediate)
        start(16'hD705);
        tick();
        e = '0; e.write = 1; e.vsel = 1; e.writenum = 3'd7; e.dp = 16'h0005; e.done = 1;
                                               chk("movimm_pos", e);
        tick();

        // ADD R5,R2,R1 with s pulsed during GET_B carrying a different word
        start(16'hA2A1);
        e = '0;                                chk("add_decode", e);
        tick();
        e = '0; e.loada = 1; e.readnum = 3'd2; chk("add_get_a", e);
        tick();
        e = '0; e.loadb = 1; e.readnum = 3'd1; chk("add_get_b", e);
        bus.s = 1'b1; bus.instr = 16'hD3FF;
        tick();
        bus.s = 1'b0; bus.instr = 16'h0000;
        e = '0; e.loadc = 1; e.aluop = 2'b00;  chk("add_alu", e);
        tick();
        e = '0; e.write = 1; e.writenum = 3'd5; e.done = 1;
                                               chk("add_write_ir_kept", e);
        tick();
        e = '0; e.w = 1'b1;                    chk("add_w_lat5", e);

        // CMP R2,R3
        start(16'hAA03);
        tick();
        e = '0; e.loada = 1; e.readnum = 3'd2; chk("cmp_get_a", e);
        tick();
        e = '0; e.loadb = 1; e.readnum = 3'd3; chk("cmp_get_b", e);
        tick();
        e = '0; e.loads = 1; e.aluop = 2'b01; e.done = 1;
                                               chk("cmp_alu", e);
        tick();
        e = '0; e.w = 1'b1;                    chk("cmp_w_lat4", e);

        // MOV R3,R0,LSL
        start(16'hC068);
        tick();
        e = '0; e.loadb = 1; e.readnum = 3'd0; chk("movreg_get_b", e);
        tick();
        e = '0; e.loadc = 1; e.asel = 1; e.shift = 2'b01; e.aluop = 2'b00;
                                               chk("movreg_alu", e);
        tick();
        e = '0; e.write = 1; e.writenum = 3'd3; e.done = 1;
                                               chk("movreg_write", e);
        tick();
        e = '0; e.w = 1'b1;                    chk("movreg_w_lat4", e);

        // MVN R7,R2, then s held high with an illegal word queued behind it
        bus.s = 1'b1; bus.instr = 16'hB8E2;
        tick();
        bus.instr = 16'h0000;
        tick();
        e = '0; e.loadb = 1; e.readnum = 3'd2; chk("mvn_get_b", e);
        tick();
        e = '0; e.loadc = 1; e.asel = 1; e.aluop = 2'b11;
                                               chk("mvn_alu", e);
        tick();
        e = '0; e.write = 1; e.writenum = 3'd7; e.done = 1;
                                               chk("mvn_write", e);
        tick();
        e = '0; e.w = 1'b1;                    chk("mvn_w_lat4", e);
        tick();
        e = '0; e.err = 1'b1;                  chk("b2b_illegal_err", e);
        bus.s = 1'b0;
        tick();
        e = '0; e.w = 1'b1;                    chk("illegal_w_lat1", e);

        // Reset during ALU of ADD
        start(16'hA2A1);
        tick();
        tick();
        tick();
        e = '0; e.loadc = 1;                   chk("abort_in_alu", e);
        #1;
        reset_n = 1'b0;
        #1;
        e = '0; e.w = 1'b1;                    chk("abort_async", e);
        tick();
        e = '0; e.w = 1'b1;                    chk("abort_no_write", e);
        #3;
        reset_n = 1'b1;

        // First start after release is accepted on the first edge
        start(16'hD1F6);
        e = '0;                                chk("post_rst_decode", e);
        tick();
        e = '0; e.write = 1; e.vsel = 1; e.writenum = 3'd1; e.dp = 16'hFFF6; e.done = 1;
                                               chk("post_rst_write", e);
        tick();
        e = '0; e.w = 1'b1;                    chk("post_rst_idle", e);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the datapath word width and datapath_in width.
REQ-002 SHALL have parameter IMMW, default 8, the immediate field width, sign-extended to WIDTH.
REQ-003 SHALL have these ports: clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 s  input  1  start request, sampled only in WAIT.
REQ-006 instr  input  16  instruction word, captured when a start is accepted.
REQ-007 readnum, writenum  output  3 each  register select outputs to the datapath.
REQ-008 loada, loadb, loadc, loads, write, vsel, asel, bsel  output  1 each  datapath control strobes.
REQ-009 shift, ALUop  output  2 each  shifter and ALU operation codes.
REQ-010 datapath_in  output  WIDTH  sign-extended immediate value.
REQ-011 w  output  1  idle/ready indicator.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 err  output  1  one-cycle undefined-opcode pulse.

Function
REQ-014 Instruction fields SHALL be: opcode [15:13], op [12:11], Rn [10:8], Rd [7:5], sh [4:3], Rm [2:0], imm [7:0].
REQ-015 States SHALL be WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, WRITE_REG.
REQ-016 In WAIT with s=1, the FSM SHALL latch instr into the internal IR and go to DECODE; s outside WAIT SHALL be ignored.
REQ-017 DECODE SHALL branch as follows: opcode 110/op 10 (MOV imm) -> WRITE_IMM; 110/00 (MOV reg) -> GET_B; 101/11 (MVN) -> GET_B; 101/00, 01, 10 (ADD, CMP, AND) -> GET_A; anything else -> WAIT with err=1.
REQ-018 WRITE_IMM SHALL assert write=1, vsel=1, writenum=Rn and datapath_in=sext(imm), then go to WAIT.
REQ-019 GET_A SHALL assert readnum=Rn and loada=1, then go to GET_B.
REQ-020 GET_B SHALL assert readnum=Rm and loadb=1, then go to ALU.
REQ-021 ALU SHALL drive shift=sh.
REQ-022 In ALU, asel SHALL be 1 (A forced to zero) for MOV reg and MVN, else 0; bsel SHALL be 0.
REQ-023 In ALU, ALUop SHALL be 00 (add) for MOV reg, 11 for MVN, and op for ADD, CMP and AND.
REQ-024 In ALU, CMP SHALL assert loads=1 and loadc=0 and go to WAIT; all others SHALL assert loadc=1 and go to WRITE_REG.
REQ-025 WRITE_REG SHALL assert write=1, vsel=0, writenum=Rd, then go to WAIT.
REQ-026 done SHALL be 1 in the final state of every defined instruction (WRITE_IMM, WRITE_REG, or ALU for CMP).
REQ-027 w SHALL be 1 exactly while in WAIT; it is a Moore output.
REQ-028 All controls not named for a state SHALL be 0, including readnum, writenum and datapath_in.
REQ-029 Accept edge to w=1 latency SHALL be: MOV imm 2, MOV reg 4, MVN 4, CMP 4, ADD/AND 5, undefined 1 cycles.
REQ-030 Back-to-back operation: s held high SHALL start the next instruction on the first WAIT cycle.
REQ-031 Rn, Rd and Rm SHALL be allowed to be equal (e.g. ADD R1,R1,R1) with no special handling.

Reset
REQ-032 reset_n=0 SHALL immediately force state to WAIT, IR to 0, all strobes and codes to 0, w=1, done=0 and err=0.
REQ-033 Reset asserted mid-instruction SHALL abort it with no write pulse after assertion.
REQ-034 After reset release, the first start SHALL be accepted on the first rising edge with s=1.

Structure
REQ-035 Package risc_pkg SHALL hold the state enum, opcode/op constants, ALUop codes (ADD 00, SUB 01, AND 10, NOT 11) and field bit positions.
REQ-036 A single combinational sub-module instr_decode SHALL extract the fields, sign-extend imm, and classify the instruction (MOV imm, MOV reg, ALU, CMP, MVN, illegal).

Verification
REQ-037 MOV imm: IR=0xD1F6 (MOV R1,#-10) -> one cycle with write=1, vsel=1, writenum=1, datapath_in=0xFFF6, done=1; w=1 two cycles after accept.
REQ-038 ADD: IR=0xA2A1 (R2, Rd=R5, Rm=R1, sh=00) -> loada with readnum=2, then loadb with readnum=1, then ALUop=00/loadc, then write with writenum=5; w=1 after 5 cycles.
REQ-039 CMP: IR=0xAA03 -> ALU state has loads=1, loadc=0, ALUop=01; no write cycle; w=1 after 4 cycles.
REQ-040 MOV reg shift / MVN: IR=0xC068 (MOV R3,R0,LSL) -> asel=1, shift=01, ALUop=00, writenum=3; IR=0xB8E2 -> ALUop=11.
REQ-041 Illegal and busy: IR=0x0000 -> err pulse, w=1 next cycle; s pulsed during GET_B -> ignored, IR unchanged.
REQ-042 Reset abort: reset_n low during ALU of ADD -> outputs 0 and w=1 asynchronously; no write ever occurs.
